wordle_board_scorer: RTL and testbench



---
 rtl/wordle_pkg.sv | 49 ++++
 rtl/wordle_board_ram.sv | 50 +++++
 rtl/wordle_board_scorer.sv | 176 +++++++++++++++++
 tb/tb_wordle_board_scorer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wordle_pkg.sv
// Shared constants, score encoding, FSM states and letter packing helpers
// for the Wordle board scorer.
package wordle_pkg;
  localparam int WORD_LEN    = 5;
  localparam int MAX_GUESSES = 6;
  localparam int LETTER_W    = 8;
  localparam int ROW_W       = 3;
  localparam int COL_W       = 3;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAX_GUESSES - 1);
  localparam logic [COL_W-1:0] LAST_IDX = COL_W'(WORD_LEN - 1);

  localparam logic [1:0] SC_EMPTY  = 2'b00;
  localparam logic [1:0] SC_GRAY   = 2'b01;
  localparam logic [1:0] SC_YELLOW = 2'b10;
  localparam logic [1:0] SC_GREEN  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_WRITE,
    S_REPORT
  } state_t;

  // Element i is letter/score position i (position 0 is the leftmost letter).
  typedef logic [WORD_LEN-1:0][LETTER_W-1:0] letters_t;
  typedef logic [WORD_LEN-1:0][1:0]          cell_scores_t;

  function automatic logic [LETTER_W-1:0] letter_at(
    input logic [WORD_LEN*LETTER_W-1:0] word,
    input int                           pos
  );
    return word[(WORD_LEN-1-pos)*LETTER_W +: LETTER_W];
  endfunction

  function automatic letters_t unpack_word(input logic [WORD_LEN*LETTER_W-1:0] word);
    letters_t l;
    for (int i = 0; i < WORD_LEN; i++) l[i] = letter_at(word, i);
    return l;
  endfunction

  function automatic logic [WORD_LEN*2-1:0] pack_scores(input cell_scores_t sc);
    logic [WORD_LEN*2-1:0] w;
    w = '0;
    for (int i = 0; i < WORD_LEN; i++) w[(WORD_LEN-1-i)*2 +: 2] = sc[i];
    return w;
  endfunction
endpackage

// File: rtl/wordle_board_ram.sv
// 6x5 board of letter+score cells: one whole-row write port, one registered
// read port that returns zeros for out-of-range coordinates.
import wordle_pkg::*;

module wordle_board_ram (
  input  logic                 Clk,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [ROW_W-1:0]     wr_row,
  input  letters_t             wr_letters,
  input  cell_scores_t         wr_scores,
  input  logic [ROW_W-1:0]     rd_row,
  input  logic [COL_W-1:0]     rd_col,
  output logic [LETTER_W-1:0]  rd_letter,
  output logic [1:0]           rd_score
);
  logic [MAX_GUESSES-1:0][WORD_LEN-1:0][LETTER_W-1:0] letter_mem;
  logic [MAX_GUESSES-1:0][WORD_LEN-1:0][1:0]          score_mem;
  logic                                               rd_in_range;

  assign rd_in_range = (rd_row < ROW_W'(MAX_GUESSES)) && (rd_col < COL_W'(WORD_LEN));

  always_ff @(posedge Clk) begin
    if (clear) begin
      letter_mem <= '0;
      score_mem  <= '0;
    end else if (wr_en) begin
      for (int r = 0; r < MAX_GUESSES; r++) begin
        if (wr_row == ROW_W'(r)) begin
          letter_mem[r] <= wr_letters;
          score_mem[r]  <= wr_scores;
        end
      end
    end
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge Clk) begin
    if (clear) begin
      rd_letter <= '0;
      rd_score  <= SC_EMPTY;
    end else if (rd_in_range) begin
      rd_letter <= letter_mem[rd_row][rd_col];
      rd_score  <= score_mem[rd_row][rd_col];
    end else begin
      rd_letter <= '0;
      rd_score  <= SC_EMPTY;
    end
  end
endmodule

// File: rtl/wordle_board_scorer.sv
// Sequential Wordle guess scorer with duplicate-aware yellow matching, board
// storage and win/lose tracking. Define WORDLE_HARD_MODE_EN to enforce reuse
// of revealed greens.
import wordle_pkg::*;

module wordle_board_scorer (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         guess_valid,
  output logic                         guess_ready,
  input  logic [WORD_LEN*LETTER_W-1:0] guess_word,
  input  logic [WORD_LEN*LETTER_W-1:0] secret_word,
  output logic                         score_valid,
  output logic [ROW_W-1:0]             score_row,
  output logic [WORD_LEN*2-1:0]        scores,
  output logic                         win,
  output logic                         lose,
  output logic                         guess_reject,
  input  logic [ROW_W-1:0]             rd_row,
  input  logic [COL_W-1:0]             rd_col,
  output logic [LETTER_W-1:0]          rd_letter,
  output logic [1:0]                   rd_score
);
  state_t              state;
  logic [COL_W-1:0]    idx;
  logic [ROW_W-1:0]    row_cnt;
  letters_t            g_q, s_q;
  cell_scores_t        sc_q;
  logic [WORD_LEN-1:0] used_q, green_q;
  logic                y_found;
  logic [COL_W-1:0]    y_idx;
  logic                hard_ok;
  logic                hs;
  logic                flush;

  assign flush = reset || clear;
  assign hs    = guess_valid && guess_ready;

  // Lowest unused secret position holding the current guess letter.
  always_comb begin
    y_found = 1'b0;
    y_idx   = '0;
    for (int j = WORD_LEN-1; j >= 0; j--) begin
      if (!used_q[j] && (s_q[j] == g_q[idx])) begin
        y_found = 1'b1;
        y_idx   = COL_W'(j);
      end
    end
  end

`ifdef WORDLE_HARD_MODE_EN
  letters_t            rev_letters;
  logic [WORD_LEN-1:0] rev_mask;
  logic                reject_q;

  always_comb begin
    hard_ok = 1'b1;
    for (int i = 0; i < WORD_LEN; i++)
      if (rev_mask[i] && (letter_at(guess_word, i) != rev_letters[i])) hard_ok = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (flush) begin
      rev_mask    <= '0;
      rev_letters <= '0;
      reject_q    <= 1'b0;
    end else begin
      reject_q <= (state == S_IDLE) && hs && !hard_ok;
      if (state == S_WRITE) begin
        for (int i = 0; i < WORD_LEN; i++) begin
          if (green_q[i]) begin
            rev_mask[i]    <= 1'b1;
            rev_letters[i] <= g_q[i];
          end
        end
      end
    end
  end

  assign guess_reject = reject_q;
`else
  assign hard_ok      = 1'b1;
  assign guess_reject = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (flush) begin
      state       <= S_IDLE;
      idx         <= '0;
      row_cnt     <= '0;
      g_q         <= '0;
      s_q         <= '0;
      sc_q        <= '0;
      used_q      <= '0;
      green_q     <= '0;
      guess_ready <= 1'b1;
      score_valid <= 1'b0;
      score_row   <= '0;
      scores      <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs && hard_ok) begin
            g_q         <= unpack_word(guess_word);
            s_q         <= unpack_word(secret_word);
            sc_q        <= '0;
            used_q      <= '0;
            green_q     <= '0;
            idx         <= '0;
            guess_ready <= 1'b0;
            state       <= S_GREEN;
          end
        end
        S_GREEN: begin
          if (g_q[idx] == s_q[idx]) begin
            sc_q[idx]    <= SC_GREEN;
            used_q[idx]  <= 1'b1;
            green_q[idx] <= 1'b1;
          end else begin
            sc_q[idx] <= SC_GRAY;
          end
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_YELLOW;
          end else begin
            idx <= idx + COL_W'(1);
          end
        end
        S_YELLOW: begin
          if (!green_q[idx] && y_found) begin
            sc_q[idx]     <= SC_YELLOW;
            used_q[y_idx] <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_WRITE;
          end else begin
            idx <= idx + COL_W'(1);
          end
        end
        S_WRITE: begin
          // Board row is written this edge; results are presented in REPORT.
          score_valid <= 1'b1;
          score_row   <= row_cnt;
          scores      <= pack_scores(sc_q);
          win         <= win || (&green_q);
          lose        <= lose || (!(&green_q) && (row_cnt == LAST_ROW));
          state       <= S_REPORT;
        end
        S_REPORT: begin
          if (row_cnt != LAST_ROW) row_cnt <= row_cnt + ROW_W'(1);
          guess_ready <= !(win || lose);
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  wordle_board_ram u_board (
    .Clk        (Clk),
    .clear      (flush),
    .wr_en      (state == S_WRITE),
    .wr_row     (row_cnt),
    .wr_letters (g_q),
    .wr_scores  (sc_q),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_letter  (rd_letter),
    .rd_score   (rd_score)
  );
endmodule

// File: tb/tb_wordle_board_scorer.sv
// Directed bench for wordle_board_scorer: table of scored guesses plus
// hand-written lose, clear-abort, read-boundary and hard-mode sequences.
module tb_wordle_board_scorer;
  logic        Clk = 1'b0;
  logic        reset, clear, guess_valid;
  logic        guess_ready, score_valid, win, lose, guess_reject;
  logic [39:0] guess_word, secret_word;
  logic [2:0]  score_row, rd_row, rd_col;
  logic [9:0]  scores;
  logic [7:0]  rd_letter;
  logic [1:0]  rd_score;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  wordle_board_scorer dut (
    .Clk(Clk), .reset(reset), .clear(clear),
    .guess_valid(guess_valid), .guess_ready(guess_ready),
    .guess_word(guess_word), .secret_word(secret_word),
    .score_valid(score_valid), .score_row(score_row), .scores(scores),
    .win(win), .lose(lose), .guess_reject(guess_reject),
    .rd_row(rd_row), .rd_col(rd_col), .rd_letter(rd_letter), .rd_score(rd_score)
  );

  typedef struct {
    logic       clr;
    logic [39:0] g;
    logic [39:0] s;
    logic [9:0] sc;
    logic [2:0] row;
    logic       w;
    logic [2:0] col;
    logic [7:0] lt;
    logic [1:0] rs;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Offer one guess, check latency, results, read-before-write on its row.
  task automatic run_guess(input logic [39:0] g, input logic [39:0] s, input logic [9:0] exp_sc,
                           input logic [2:0] row, input logic exp_win, input logic exp_lose);
    int k;
    logic [7:0] l0;
    l0 = g[39:32];
    rd_row = row; rd_col = 3'd0;
    guess_word = g; secret_word = s; guess_valid = 1'b1;
    chk("ready_before", guess_ready, 1);
    tick();
    guess_valid = 1'b0; guess_word = "ZZZZZ"; secret_word = "QQQQQ";
    chk("ready_busy", guess_ready, 0);
    chk("no_reject", guess_reject, 0);
    k = 1;
    while (!score_valid && k < 30) begin
      tick();
      k++;
    end
    chk("latency", k, 12);
    chk("scores", scores, exp_sc);
    chk("score_row", score_row, row);
    chk("win", win, exp_win);
    chk("lose", lose, exp_lose);
    chk("rd_old", rd_letter, 0);
    tick();
    chk("valid_pulse", score_valid, 0);
    chk("rd_new", rd_letter, l0);
    chk("ready_after", guess_ready, !(exp_win || exp_lose));
  endtask

  // Hold guess_valid for n cycles and expect no scoring to start.
  task automatic expect_blocked(input string name, input int n);
    int seen;
    seen = 0;
    guess_word = "CRANE"; secret_word = "CRANE"; guess_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (guess_ready || score_valid) seen++;
      if (i == 1) guess_valid = 1'b0;
    end
    guess_valid = 1'b0;
    chk(name, seen, 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, "BABES", "ABBEY", 10'b1010111101, 3'd0, 1'b0, 3'd1, "A", 2'b10};
    tbl[1] = '{1'b1, "EERIE", "CRANE", 10'b0101100111, 3'd0, 1'b0, 3'd3, "I", 2'b01};
    tbl[2] = '{1'b0, "NACRE", "CRANE", 10'b1010101011, 3'd1, 1'b0, 3'd4, "E", 2'b11};
    tbl[3] = '{1'b1, "CRANE", "CRANE", 10'b1111111111, 3'd0, 1'b1, 3'd0, "C", 2'b11};

    reset = 1'b1; clear = 1'b0; guess_valid = 1'b0;
    guess_word = '0; secret_word = '0; rd_row = '0; rd_col = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", guess_ready, 1);
    chk("rst_valid", score_valid, 0);
    chk("rst_winlose", {win, lose, guess_reject}, 0);
    chk("rst_outs", {scores, score_row}, 0);
    chk("rst_rd", {rd_letter, rd_score}, 0);

    // Table of scored guesses with a read-back of one cell each.
    for (int v = 0; v < 4; v++) begin
      if (tbl[v].clr) do_clear();
      run_guess(tbl[v].g, tbl[v].s, tbl[v].sc, tbl[v].row, tbl[v].w, 1'b0);
      rd_row = tbl[v].row; rd_col = tbl[v].col;
      tick();
      chk("tbl_rd_letter", rd_letter, tbl[v].lt);
      chk("tbl_rd_score", rd_score, tbl[v].rs);
    end

    // After win: sticky, no further handshakes.
    expect_blocked("win_blocked", 16);
    chk("win_sticky", win, 1);

    // Read boundaries on a populated board.
    rd_row = 3'd6; rd_col = 3'd0; tick();
    chk("rd_row6", {rd_letter, rd_score}, 0);
    rd_row = 3'd0; rd_col = 3'd5; tick();
    chk("rd_col5", {rd_letter, rd_score}, 0);
    rd_row = 3'd7; rd_col = 3'd7; tick();
    chk("rd_row7", {rd_letter, rd_score}, 0);

    // Lose: six all-gray guesses.
    do_clear();
    chk("clear_win", win, 0);
    run_guess("BUILT", "CRANE", 10'b0101010101, 3'd0, 1'b0, 1'b0);
    run_guess("DOUBT", "CRANE", 10'b0101010101, 3'd1, 1'b0, 1'b0);
    run_guess("FIGHT", "CRANE", 10'b0101010101, 3'd2, 1'b0, 1'b0);
    run_guess("JUMPY", "CRANE", 10'b0101010101, 3'd3, 1'b0, 1'b0);
    run_guess("MISTY", "CRANE", 10'b0101010101, 3'd4, 1'b0, 1'b0);
    run_guess("WOULD", "CRANE", 10'b0101010101, 3'd5, 1'b0, 1'b1);
    expect_blocked("lose_blocked", 16);
    chk("lose_sticky", lose, 1);

    // Clear while in YELLOW aborts the guess.
    do_clear();
    rd_row = 3'd0; rd_col = 3'd0;
    guess_word = "CRANE"; secret_word = "CRANE"; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_ready", guess_ready, 1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
        if (score_valid) seen++;
        tick();
      end
      chk("abort_no_valid", seen, 0);
    end
    chk("abort_rd", {rd_letter, rd_score}, 0);
    chk("abort_win", win, 0);
    run_guess("BUILT", "CRANE", 10'b0101010101, 3'd0, 1'b0, 1'b0);

    do_clear();
    run_guess("CHOSE", "CRANE", 10'b1101010111, 3'd0, 1'b0, 1'b0);
`ifdef WORDLE_HARD_MODE_EN
    // TRACE drops the revealed green C at position 0.
    guess_word = "TRACE"; secret_word = "CRANE"; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    chk("reject_pulse", guess_reject, 1);
    chk("reject_ready", guess_ready, 1);
    tick();
    chk("reject_end", guess_reject, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 14; i++) begin
        if (score_valid) seen++;
        tick();
      end
      chk("reject_no_valid", seen, 0);
    end
    run_guess("CRANE", "CRANE", 10'b1111111111, 3'd1, 1'b1, 1'b0);
`else
    run_guess("TRACE", "CRANE", 10'b0111111011, 3'd1, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
